// File: rtl/seq_gen_ctrl.sv
// seq_gen_ctrl
// Burst controller for a WIDTH-bit shift-register sequence generator.
// It drives Johnson or ring sequences in the forward or reverse direction.
// A requester starts a burst of len patterns, or a free-run when len=0.
// The controller owns the register, sanitises ring seeds and repairs
// illegal register states. Every flop updates on the falling edge of clk.
//
// Ports
//   clk      : clock; state changes on negedge
//   rst      : synchronous active-high reset, sampled on negedge
//   start    : begin a burst (honoured only in IDLE)
//   stop     : abort a running burst (honoured only in RUN)
//   mode     : 00 Johnson fwd, 01 ring fwd, 10 Johnson rev, 11 ring rev
//   len      : patterns per burst, 0 = free-run
//   seed     : ring-mode initial value
//   q        : current pattern
//   q_valid  : q holds a burst pattern
//   busy     : controller is not IDLE
//   done     : one-cycle pulse when a burst finishes
//   step_cnt : patterns issued minus one in the current burst
//   illegal  : one-cycle pulse when a seed or register state was corrected
module seq_gen_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] step_cnt,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] RING_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] step_cnt_q, step_cnt_d;
  logic             illegal_q, illegal_d;
  logic [1:0]       mode_q, mode_d;   // bit0: ring, bit1: reverse
  logic [LEN_W-1:0] len_q, len_d;

  logic [WIDTH-2:0] edges;            // adjacent-bit differences of q
  logic             q_legal;
  logic             last_step;

  always_comb begin
    edges     = q_q[WIDTH-2:0] ^ q_q[WIDTH-1:1];
    // A Johnson pattern is a single run of ones and a single run of zeros,
    // so it has at most one boundary between neighbouring bits.
    q_legal   = mode_q[0] ? ($countones(q_q) == 1) : ($countones(edges) <= 1);
    last_step = (len_q != '0) && (step_cnt_q == (len_q - LEN_W'(1)));
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    step_cnt_d = step_cnt_q;
    mode_d     = mode_q;
    len_d      = len_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          len_d      = len;
          step_cnt_d = '0;
          q_valid_d  = 1'b1;
          state_d    = S_RUN;
          if (mode[0]) begin
            if ($countones(seed) == 1) begin
              q_d = seed;
            end else begin
              q_d       = RING_ONE;
              illegal_d = 1'b1;
            end
          end else begin
            q_d = '0;
          end
        end
      end

      S_RUN: begin
        // Termination freezes q on the last pattern; stop beats advance.
        if (stop || last_step) begin
          state_d   = S_DONE;
          q_valid_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + LEN_W'(1);
          if (!q_legal) begin
            // Recovery restarts from the mode's canonical value, never the seed.
            q_d       = mode_q[0] ? RING_ONE : '0;
            illegal_d = 1'b1;
          end else begin
            case (mode_q)
              2'b00:   q_d = {~q_q[0], q_q[WIDTH-1:1]};
              2'b01:   q_d = {q_q[0], q_q[WIDTH-1:1]};
              2'b10:   q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
              default: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            endcase
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_cnt_q <= '0;
      illegal_q  <= 1'b0;
      mode_q     <= 2'b00;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_cnt_q <= step_cnt_d;
      illegal_q  <= illegal_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
    end
  end

  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_cnt = step_cnt_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Testbench for seq_gen_ctrl. Inputs are driven just after the rising edge,
// the DUT and the reference model update on the falling edge, and outputs
// are compared on the rising edge.
module tb_seq_gen_ctrl;
  localparam int W  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [1:0]    mode;
  logic [LW-1:0] len;
  logic [W-1:0]  seed;
  logic [W-1:0]  q;
  logic          q_valid, busy, done, illegal;
  logic [LW-1:0] step_cnt;

  always #5 clk = ~clk;

  seq_gen_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .len(len), .seed(seed), .q(q), .q_valid(q_valid), .busy(busy),
    .done(done), .step_cnt(step_cnt), .illegal(illegal)
  );

  int vectors = 0;
  int errors  = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern k of a burst computed directly: a Johnson sequence is a run of
  // ones growing then shrinking; a ring sequence is a single one rotating.
  function automatic logic [W-1:0] pat(input logic [1:0] md, input int k, input int pos);
    logic [W-1:0] r;
    int kk;
    r = '0;
    if (!md[0]) begin
      kk = k % (2 * W);
      for (int b = 0; b < W; b++) begin
        if (!md[1]) r[b] = (kk <= W) ? (b >= W - kk) : (b < 2 * W - kk);
        else        r[b] = (kk <= W) ? (b < kk)      : (b >= kk - W);
      end
    end else begin
      if (md[1]) r[(pos + k) % W] = 1'b1;
      else       r[(pos - (k % W) + W) % W] = 1'b1;
    end
    return r;
  endfunction

  // Reference model
  int            m_st = 0;    // 0 idle, 1 running, 2 finishing
  int            m_k, m_pos, m_len;
  logic [1:0]    m_mode;
  logic [W-1:0]  e_q = '0;
  logic          e_qv = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ill = 1'b0;
  logic [LW-1:0] e_step = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_st = 0; e_q = '0; e_qv = 1'b0; e_busy = 1'b0;
      e_done = 1'b0; e_step = '0; e_ill = 1'b0;
    end else begin
      case (m_st)
        0: begin
          e_done = 1'b0;
          e_ill  = 1'b0;
          if (start) begin
            m_mode = mode;
            m_len  = int'(len);
            m_k    = 0;
            m_pos  = 0;
            if (mode[0]) begin
              if ($countones(seed) == 1) begin
                for (int b = 0; b < W; b++) if (seed[b]) m_pos = b;
              end else begin
                e_ill = 1'b1;
              end
            end
            e_q = pat(m_mode, 0, m_pos);
            e_qv = 1'b1; e_busy = 1'b1; e_step = '0;
            m_st = 1;
          end
        end
        1: begin
          e_ill = 1'b0;
          if (stop || (m_len != 0 && m_k + 1 == m_len)) begin
            m_st = 2; e_qv = 1'b0; e_done = 1'b1;
          end else begin
            m_k++;
            e_q    = pat(m_mode, m_k, m_pos);
            e_step = LW'(m_k % (1 << LW));
          end
        end
        default: begin
          m_st = 0; e_busy = 1'b0; e_done = 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (check_en) begin
      chk("model_q",        32'(q),        32'(e_q));
      chk("model_q_valid",  32'(q_valid),  32'(e_qv));
      chk("model_busy",     32'(busy),     32'(e_busy));
      chk("model_done",     32'(done),     32'(e_done));
      chk("model_step_cnt", 32'(step_cnt), 32'(e_step));
      chk("model_illegal",  32'(illegal),  32'(e_ill));
    end
  end

  task automatic nxt();
    @(posedge clk);
  endtask

  // Runs until busy drops, counting valid cycles; bounded.
  task automatic finish_burst(output int nvalid);
    int guard;
    nvalid = 0;
    guard  = 0;
    while (busy && guard < 400) begin
      if (q_valid) nvalid++;
      nxt();
      guard++;
    end
    if (guard >= 400) chk("burst_timeout", 32'(guard), 32'(0));
  endtask

  logic [W-1:0] j_fwd [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [W-1:0] j_rev [3] = '{4'b0000, 4'b0001, 4'b0011};
  logic [W-1:0] r_fwd [6] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; len = '0; seed = '0;
    nxt(); nxt();
    check_en = 1'b1;
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;

    // Johnson forward, len 8
    mode = 2'b00; len = 8'd8; start = 1'b1; nxt(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_q", 32'(q), 32'(j_fwd[i]));
      chk("t1_q_valid", 32'(q_valid), 32'(1));
      nxt();
    end
    chk("t1_done", 32'(done), 32'(1));
    chk("t1_q_hold", 32'(q), 32'(4'b0001));
    chk("t1_q_valid_off", 32'(q_valid), 32'(0));
    nxt();
    chk("t1_busy_off", 32'(busy), 32'(0));

    // Johnson reverse, len 3
    mode = 2'b10; len = 8'd3; start = 1'b1; nxt(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_q", 32'(q), 32'(j_rev[i]));
      nxt();
    end
    chk("t2_done", 32'(done), 32'(1));
    chk("t2_step_cnt", 32'(step_cnt), 32'(2));
    nxt();

    // Ring forward free-run, stop at step 5
    mode = 2'b01; seed = 4'b0001; len = '0; start = 1'b1; nxt(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t3_q", 32'(q), 32'(r_fwd[i]));
      chk("t3_step_cnt", 32'(step_cnt), 32'(i));
      if (i == 5) stop = 1'b1;
      nxt();
    end
    stop = 1'b0;
    chk("t3_done", 32'(done), 32'(1));
    chk("t3_q_hold", 32'(q), 32'(4'b1000));
    nxt();

    // Free-run step counter wrap
    start = 1'b1; nxt(); start = 1'b0;
    repeat (255) nxt();
    chk("wrap_step_max", 32'(step_cnt), 32'(255));
    nxt();
    chk("wrap_step_zero", 32'(step_cnt), 32'(0));
    chk("wrap_busy", 32'(busy), 32'(1));
    stop = 1'b1; nxt(); stop = 1'b0;
    finish_burst(cnt);

    // Ring reverse with bad seeds
    mode = 2'b11; seed = 4'b0110; len = '0; start = 1'b1; nxt(); start = 1'b0;
    chk("t4_q0", 32'(q), 32'(4'b0001));
    chk("t4_illegal", 32'(illegal), 32'(1));
    nxt();
    chk("t4_q1", 32'(q), 32'(4'b0010));
    chk("t4_illegal_clr", 32'(illegal), 32'(0));
    nxt();
    chk("t4_q2", 32'(q), 32'(4'b0100));
    stop = 1'b1; nxt(); stop = 1'b0;
    finish_burst(cnt);
    seed = 4'b0000; start = 1'b1; nxt(); start = 1'b0;
    chk("t4_zero_seed_q", 32'(q), 32'(4'b0001));
    chk("t4_zero_seed_illegal", 32'(illegal), 32'(1));
    stop = 1'b1; nxt(); stop = 1'b0;
    finish_burst(cnt);

    // Inputs changed mid-burst are ignored
    mode = 2'b00; len = 8'd4; start = 1'b1; nxt(); start = 1'b0;
    nxt();
    start = 1'b1; mode = 2'b01; len = 8'd2;
    nxt();
    start = 1'b0;
    finish_burst(cnt);
    chk("t5_len_kept", 32'(cnt + 2), 32'(4));
    chk("t5_last_q", 32'(q), 32'(4'b1110));

    // start and stop together in IDLE, len 1
    mode = 2'b00; len = 8'd1; start = 1'b1; stop = 1'b1; nxt();
    start = 1'b0; stop = 1'b0;
    chk("t5_start_wins", 32'(busy), 32'(1));
    finish_burst(cnt);
    chk("t5_len1_valid", 32'(cnt), 32'(1));

    // Reset mid-run
    mode = 2'b00; len = '0; start = 1'b1; nxt(); start = 1'b0;
    nxt(); nxt(); nxt();
    chk("t6_step3", 32'(step_cnt), 32'(3));
    rst = 1'b1; nxt();
    chk("t6_q", 32'(q), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_step", 32'(step_cnt), 32'(0));
    rst = 1'b0;
    len = 8'd2; start = 1'b1; nxt(); start = 1'b0;
    chk("t6_restart_q", 32'(q), 32'(0));
    chk("t6_restart_busy", 32'(busy), 32'(1));
    finish_burst(cnt);
    chk("t6_restart_len", 32'(cnt), 32'(2));

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
